// File: rtl/cpu_wr_out_flags_pkg.sv
// Shared constants for the CPU write-direction output-flags port.
// Holds the register word addresses and the STATUS bit positions.
package cpu_wr_out_flags_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_PULSE    = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_IRQ  = 1;

endpackage

// File: rtl/cpu_wr_out_flags_pulse.sv
// Self-timed one-shot pulse engine.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   arm          : load the counter and apply bits (caller guarantees bits != 0)
//   bits         : flags to assert
//   pulse_port   : one-shot flag outputs, high for PULSE_CYCLES cycles after arm
//   busy         : counter non-zero
//   done         : counter is about to go 1->0 with no simultaneous re-arm
module cpu_wr_out_flags_pulse #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] bits,
  output logic [DATA_WIDTH-1:0] pulse_port,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(PULSE_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0]       cnt_d, cnt_q;
  logic [DATA_WIDTH-1:0] pulse_d, pulse_q;
  logic                  last;

  assign last = (cnt_q == CntOne);

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    if (arm) begin
      cnt_d = CntLoad;
      // Only extend bits that would still be high next cycle; on the last
      // cycle (or when idle) the old bits are dropped and replaced.
      pulse_d = (cnt_q <= CntOne) ? bits : (pulse_q | bits);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntOne;
      if (last) begin
        pulse_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      pulse_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_port = pulse_q;
  assign busy       = (cnt_q != '0);
  assign done       = last & ~arm;

endmodule

// File: rtl/cpu_wr_out_flags.sv
// Avalon-MM slave output-flags port: level register with atomic set/clear,
// self-timed one-shot pulses, change strobe and registered read-back.
// Optional pulse-done interrupt enabled by defining CPU_WR_OUT_FLAGS_IRQ_EN.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave request (no wait states)
//   readdata              : registered read data, valid one cycle after address
//   out_port, out_strobe  : level flags and one-cycle change strobe
//   pulse_port            : one-shot flags
//   irq                   : pulse-done interrupt (0 when feature disabled)
module cpu_wr_out_flags
  import cpu_wr_out_flags_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned           PULSE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_strobe,
  output logic [DATA_WIDTH-1:0] pulse_port,
  output logic                  irq
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] out_d, out_q;
  logic                  strobe_d, strobe_q;
  logic [31:0]           rd_d, rd_q;
  logic                  pulse_arm, pulse_busy, pulse_done;
  logic                  irq_pending;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign pulse_arm = wr & (address == ADDR_PULSE) & (wd != '0);

  cpu_wr_out_flags_pulse #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse (
    .clk        (clk),
    .reset_n    (reset_n),
    .arm        (pulse_arm),
    .bits       (wd),
    .pulse_port (pulse_port),
    .busy       (pulse_busy),
    .done       (pulse_done)
  );

  always_comb begin
    out_d = out_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     out_d = wd;
        ADDR_OUTSET:   out_d = out_q | wd;
        ADDR_OUTCLEAR: out_d = out_q & ~wd;
        default:       out_d = out_q;
      endcase
    end
    // out_d only moves on DATA/OUTSET/OUTCLEAR writes, so a value change
    // is sufficient to qualify the strobe.
    strobe_d = (out_d != out_q);
  end

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:  rd_d[DATA_WIDTH-1:0] = out_q;
      ADDR_PULSE: rd_d[DATA_WIDTH-1:0] = pulse_port;
      ADDR_STATUS: begin
        rd_d[ST_BUSY] = pulse_busy;
        rd_d[ST_IRQ]  = irq_pending;
      end
      default:    rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q    <= RESET_VALUE;
      strobe_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      out_q    <= out_d;
      strobe_q <= strobe_d;
      rd_q     <= rd_d;
    end
  end

`ifdef CPU_WR_OUT_FLAGS_IRQ_EN
  logic pend_d, pend_q;

  always_comb begin
    pend_d = pend_q;
    if (wr && (address == ADDR_STATUS) && writedata[ST_IRQ]) begin
      pend_d = 1'b0;
    end
    // Set has priority over a simultaneous clear.
    if (pulse_done) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign irq_pending = pend_q;
  assign irq         = pend_q;
`else
  logic unused_done;
  assign unused_done = pulse_done;
  assign irq_pending = 1'b0;
  assign irq         = 1'b0;
`endif

  assign out_port   = out_q;
  assign out_strobe = strobe_q;
  assign readdata   = rd_q;

endmodule

// File: tb/tb_cpu_wr_out_flags.sv
module tb_cpu_wr_out_flags;

  localparam int unsigned DW    = 8;
  localparam logic [7:0]  RV    = 8'hA5;
  localparam int unsigned PC    = 4;
`ifdef CPU_WR_OUT_FLAGS_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        out_strobe;
  logic [7:0]  pulse_port;
  logic        irq;

  cpu_wr_out_flags #(
    .DATA_WIDTH   (DW),
    .RESET_VALUE  (RV),
    .PULSE_CYCLES (PC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_strobe (out_strobe),
    .pulse_port (pulse_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pulses tracked by the absolute edge index at which
  // they end, rather than by a down-counter.
  int         m_cur;      // number of clock edges processed
  int         m_end;      // pulse visible while m_cur < m_end
  logic [7:0] m_bits;
  logic [7:0] m_out;
  logic       m_stb;
  logic [31:0] m_rd;
  logic       m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_pulse();
    return (m_cur < m_end) ? m_bits : 8'h00;
  endfunction

  task automatic model_reset();
    m_end  = m_cur;
    m_bits = 8'h00;
    m_out  = RV;
    m_stb  = 1'b0;
    m_rd   = 32'h0;
    m_pend = 1'b0;
  endtask

  task automatic model_edge(input logic cs, input logic wn, input logic [2:0] a,
                            input logic [31:0] wdat);
    logic       wr;
    logic [7:0] w;
    logic [7:0] old_out;
    logic       arm;
    int         n;
    wr = cs & ~wn;
    w  = wdat[7:0];
    n  = m_cur + 1;
    case (a)
      3'd0:    m_rd = {24'h0, m_out};
      3'd1:    m_rd = {24'h0, m_pulse()};
      3'd2:    m_rd = {30'h0, m_pend, (m_cur < m_end)};
      default: m_rd = 32'h0;
    endcase
    old_out = m_out;
    if (wr && a == 3'd0) m_out = w;
    if (wr && a == 3'd4) m_out = m_out | w;
    if (wr && a == 3'd5) m_out = m_out & ~w;
    m_stb = (m_out != old_out);
    arm = wr && a == 3'd1 && w != 8'h00;
    if (IRQ_ON && wr && a == 3'd2 && wdat[1]) m_pend = 1'b0;
    if (IRQ_ON && !arm && m_end == n) m_pend = 1'b1;
    if (arm) begin
      m_bits = (m_end > n) ? (m_bits | w) : w;
      m_end  = n + PC;
    end
    m_cur = n;
  endtask

  task automatic compare_all();
    chk("out_port",   {24'h0, out_port},   {24'h0, m_out});
    chk("out_strobe", {31'h0, out_strobe}, {31'h0, m_stb});
    chk("pulse_port", {24'h0, pulse_port}, {24'h0, m_pulse()});
    chk("readdata",   readdata,            m_rd);
    chk("irq",        {31'h0, irq},        {31'h0, m_pend});
  endtask

  task automatic step(input logic cs, input logic wn, input logic [2:0] a,
                      input logic [31:0] wdat);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wdat;
    @(posedge clk);
    #1;
    model_edge(cs, wn, a, wdat);
    compare_all();
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wdat);
    step(1'b1, 1'b0, a, wdat);
  endtask

  task automatic idle(input logic [2:0] a);
    step(1'b0, 1'b1, a, 32'h0);
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic        exp_stb;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [7:0] exp_p[7];

    m_cur      = 0;
    model_reset();
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;

    vt[0] = '{1'b1, 1'b0, 3'd0, 32'h0000_003C, 8'h3C, 1'b1};
    vt[1] = '{1'b1, 1'b0, 3'd4, 32'h0000_0003, 8'h3F, 1'b1};
    vt[2] = '{1'b1, 1'b0, 3'd5, 32'h0000_0030, 8'h0F, 1'b1};
    vt[3] = '{1'b1, 1'b0, 3'd4, 32'h0000_0003, 8'h0F, 1'b0};
    vt[4] = '{1'b0, 1'b0, 3'd0, 32'h0000_00FF, 8'h0F, 1'b0};
    vt[5] = '{1'b1, 1'b1, 3'd0, 32'h0000_00FF, 8'h0F, 1'b0};
    vt[6] = '{1'b1, 1'b0, 3'd3, 32'h0000_00FF, 8'h0F, 1'b0};
    vt[7] = '{1'b1, 1'b0, 3'd0, 32'hFFFF_FF5A, 8'h5A, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_port",   {24'h0, out_port},   32'h0000_00A5);
    chk("rst_pulse_port", {24'h0, pulse_port}, 32'h0);
    chk("rst_readdata",   readdata,            32'h0);
    chk("rst_strobe",     {31'h0, out_strobe}, 32'h0);
    chk("rst_irq",        {31'h0, irq},        32'h0);
    #2 reset_n = 1'b1;

    idle(3'd0);
    chk("rd_data_after_reset", readdata, 32'h0000_00A5);

    // Level register table
    for (int i = 0; i < 8; i++) begin
      step(vt[i].cs, vt[i].wn, vt[i].addr, vt[i].wd);
      chk($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vt[i].exp_out});
      chk($sformatf("vec%0d_stb", i), {31'h0, out_strobe}, {31'h0, vt[i].exp_stb});
    end
    idle(3'd0);
    chk("readback_after_write", readdata, 32'h0000_005A);

    // Single pulse
    wr_reg(3'd1, 32'h01);
    chk("p1_c1", {24'h0, pulse_port}, 32'h01);
    idle(3'd2);
    chk("p1_c2", {24'h0, pulse_port}, 32'h01);
    idle(3'd2);
    chk("p1_busy", readdata, {31'h0, 1'b1});
    chk("p1_c3", {24'h0, pulse_port}, 32'h01);
    idle(3'd0);
    chk("p1_c4", {24'h0, pulse_port}, 32'h01);
    idle(3'd0);
    chk("p1_c5", {24'h0, pulse_port}, 32'h00);
    chk("p1_irq", {31'h0, irq}, {31'h0, IRQ_ON});
    wr_reg(3'd2, 32'h2);
    chk("p1_irq_clr", {31'h0, irq}, 32'h0);

    // Overlapping pulses, zero write mid-pulse
    exp_p = '{8'h01, 8'h01, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00};
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      wr_reg(3'd1, 32'h01);
      else if (i == 2) wr_reg(3'd1, 32'h02);
      else if (i == 3) wr_reg(3'd1, 32'h00);
      else             idle(3'd1);
      chk($sformatf("p2_c%0d", i + 1), {24'h0, pulse_port}, {24'h0, exp_p[i]});
    end
    wr_reg(3'd2, 32'h2);

    // Re-arm on the last cycle replaces bits and suppresses the interrupt
    wr_reg(3'd1, 32'h01);
    repeat (3) idle(3'd0);
    wr_reg(3'd1, 32'h04);
    chk("p3_rearm_bits", {24'h0, pulse_port}, 32'h04);
    idle(3'd0);
    chk("p3_no_irq", {31'h0, irq}, 32'h0);
    repeat (3) idle(3'd0);
    chk("p3_end", {24'h0, pulse_port}, 32'h00);
    chk("p3_irq", {31'h0, irq}, {31'h0, IRQ_ON});
    wr_reg(3'd2, 32'h2);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w = w & 32'hFFFF_FF00;
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)), w);
    end

    // Reset mid-pulse with two cycles left
    wr_reg(3'd1, 32'h81);
    idle(3'd0);
    idle(3'd0);
    chk("pre_rst_pulse", {24'h0, pulse_port}, 32'h81);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_pulse", {24'h0, pulse_port}, 32'h0);
    chk("async_rst_out",   {24'h0, out_port},   32'h0000_00A5);
    chk("async_rst_rd",    readdata,            32'h0);
    #1 reset_n = 1'b1;
    idle(3'd2);
    idle(3'd2);
    chk("post_rst_status", readdata, 32'h0);
    wr_reg(3'd0, 32'h55);
    chk("post_rst_out", {24'h0, out_port}, 32'h55);
    chk("post_rst_stb", {31'h0, out_strobe}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_wr_out_flags.md
Name: cpu_wr_out_flags

Overview:
- Avalon-MM slave output port: the CPU writes flag bits that drive the LED-panel control fabric. It is the write-direction counterpart of the CPU input-flags port.
- Provides a level register with atomic set/clear, self-timed one-shot pulse outputs, and a change strobe for the consumer.
- Read-back has registered readdata with 1-cycle latency, same timing as the input-flags port.

Parameters:
- DATA_WIDTH, 8, width of out_port and pulse_port (1..32)
- RESET_VALUE, 0, value loaded into out_port on reset
- PULSE_CYCLES, 4, number of cycles each pulse_port assertion lasts (>=1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data; bits above DATA_WIDTH ignored
- readdata  out  32  registered read data
- out_port  out  DATA_WIDTH  level flags
- out_strobe  out  1  one-cycle pulse, high during the first cycle a changed out_port value is visible
- pulse_port  out  DATA_WIDTH  one-shot flags
- irq  out  1  pulse-done interrupt (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): out_port=RESET_VALUE; pulse_port=0; pulse counter=0; out_strobe=0; readdata=0; irq=0 and pending=0.
- wr = chipselect & ~write_n. There are no wait states; every access completes in one cycle.
- Address map:
  - 0 DATA: write loads out_port; read returns out_port.
  - 1 PULSE: write arms pulses; read returns pulse_port.
  - 2 STATUS: read bit0=pulse_busy (counter!=0), bit1=irq_pending; write of 1 to bit1 clears pending.
  - 4 OUTSET: write ORs into out_port; reads 0.
  - 5 OUTCLEAR: write clears bits where writedata=1; reads 0.
  - 3, 6, 7: writes ignored; reads 0.
- readdata is updated every clock with the zero-extended mux of address. It is valid the cycle after address is presented, independent of chipselect.
- A read of the same address in the cycle after a write returns the new value.
- out_strobe <= wr & (addr in {0,4,5}) & (next out_port != out_port). A write that leaves out_port unchanged produces no strobe. Back-to-back changing writes give a strobe in consecutive cycles.
- Pulse engine:
  - A write to PULSE with wd=writedata[DATA_WIDTH-1:0]!=0 reloads counter=PULSE_CYCLES and sets pulse_port.
  - If the counter is idle or at its last cycle (counter<=1), pulse_port <= wd. Otherwise pulse_port <= pulse_port|wd; all active bits are extended.
  - With no write, counter decrements while nonzero. When the counter goes 1->0, pulse_port <= 0.
  - Result: a write at cycle T gives pulse_port high for cycles T+1..T+PULSE_CYCLES.
  - A write of 0 to PULSE has no effect and does not cancel an active pulse.
- Counter width is $clog2(PULSE_CYCLES+1). The counter never wraps: it saturates at 0.
- A reset during an active pulse drops pulse_port immediately.

Optional Feature:
- Macro CPU_WR_OUT_FLAGS_IRQ_EN.
- Defined:
  - irq_pending is set in the cycle the counter goes 1->0 without a simultaneous re-arm.
  - irq = irq_pending, registered.
  - A STATUS write with bit1=1 clears pending. If a set and a clear occur in the same cycle, set wins.
- Undefined: irq is tied 0, STATUS bit1 reads 0, and no pending flop is implemented. The port list is unchanged.

Decomposition:
- Package cpu_wr_out_flags_pkg holds:
  - address localparams ADDR_DATA=0, ADDR_PULSE=1, ADDR_STATUS=2, ADDR_OUTSET=4, ADDR_OUTCLEAR=5
  - status bit indices ST_BUSY=0, ST_IRQ=1
- Sub-module cpu_wr_out_flags_pulse contains the counter, pulse_port register and done indication. Its inputs are arm and bits; its outputs are pulse_port, busy and done.
- The top module holds the register file, strobe, read mux and irq.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=A5, pulse_port=0, readdata=0, out_strobe=0, irq=0; read addr0 gives readdata=0x000000A5 one cycle later.
- Write 0x3C to DATA, then OUTSET 0x03, then OUTCLEAR 0x30 -> out_port goes 3C, 3F, 0F with out_strobe high for 3 consecutive cycles; a second OUTSET 0x03 gives no strobe.
- PULSE write 0x01 at T with PULSE_CYCLES=4 -> pulse_port=01 for T+1..T+4 and 0 at T+5; STATUS bit0=1 while active.
- PULSE write 0x01 at T, then 0x02 at T+2 -> pulse_port=03 from T+3 to T+6 and 0 at T+7; a write of 0x00 mid-pulse causes no change.
- With CPU_WR_OUT_FLAGS_IRQ_EN: pulse expires -> irq=1 the following cycle; STATUS write 0x2 -> irq=0; a re-arm on the last cycle gives no irq. Without the macro, irq stays 0 throughout.
- Assert reset_n low mid-pulse (counter=2) -> pulse_port and counter are 0 immediately (asynchronously); after release, the first DATA write works normally.
